// File: rtl/rx_video_pkg.sv
// Shared definitions for the receive-side video reassembler: framing defaults,
// FSM encoding, FIFO entry layout and the RGB444 -> RGB888 expansion.
package rx_video_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FIFO_W       = 26;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    RECV      = 2'd1,
    DROP      = 2'd2
  } state_e;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [23:0] rgb;
  } pix_entry_t;

  // Replicating each nibble maps 0x0 -> 0x00 and 0xF -> 0xFF exactly.
  function automatic logic [23:0] expand_rgb444(input logic [11:0] p);
    return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

endpackage

// File: rtl/rx_pix_fifo.sv
// Synchronous FIFO whose head entry sits in a registered read stage; the entry
// being presented stays counted until it is handshaken, so capacity is DEPTH.
module rx_pix_fifo #(
  parameter  int WIDTH = 26,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q;
  logic             push, pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push    = wr_en_i && !full_o;
  assign pop     = valid_q && rd_ready_i;

  // Valid is derived from the post-pop count excluding this cycle's write,
  // which is what gives the one-cycle write-to-valid latency.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    valid_d  = (wr_ptr_q != rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      data_q   <= mem[rd_ptr_d[AW-1:0]];
    end
  end

  assign rd_valid_o = valid_q;
  assign rd_data_o  = data_q;

endmodule

// File: rtl/rx_video_unpack.sv
// Rebuilds frame/line framing for received RGB444 pixels and presents them as
// an AXI4-Stream video master with a small backpressure FIFO.
module rx_video_unpack
  import rx_video_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] RxData,
  input  logic        RxValid,
  input  logic        FrameSync,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  output logic [15:0] frame_cnt,
  output logic        overflow,
  output logic        short_frame,
  input  logic        clr_status
);

  localparam int          FIFO_AW = $clog2(FIFO_DEPTH);
  localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [8:0]  Y_LAST  = 9'(V_ACTIVE - 1);

  state_e       state_q, state_d, cur_state;
  logic [9:0]   x_q, x_d, cur_x;
  logic [8:0]   y_q, y_d, cur_y;
  logic [15:0]  frame_cnt_q;
  logic         overflow_q, short_frame_q;
  logic         frame_done, set_ovf, set_short;

  logic         wr_en;
  pix_entry_t   wr_entry;
  pix_entry_t   rd_entry;
  logic         fifo_full, fifo_empty, fifo_valid;
  logic [FIFO_AW:0] fifo_count;
  logic         unused_fifo_status;

  // FrameSync is resolved first so a coincident pixel becomes pixel (0,0).
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cur_state  = state_q;
    cur_x      = x_q;
    cur_y      = y_q;
    wr_en      = 1'b0;
    wr_entry   = '0;
    frame_done = 1'b0;
    set_ovf    = 1'b0;
    set_short  = 1'b0;

    if (FrameSync) begin
      if (state_q == RECV && (x_q != '0 || y_q != '0)) begin
        set_short = 1'b1;
      end
      cur_state = RECV;
      cur_x     = '0;
      cur_y     = '0;
      state_d   = RECV;
      x_d       = '0;
      y_d       = '0;
    end

    if (cur_state == RECV && RxValid) begin
      if (fifo_full) begin
        set_ovf = 1'b1;
        state_d = DROP;
      end else begin
        wr_en          = 1'b1;
        wr_entry.tuser = (cur_x == '0) && (cur_y == '0);
        wr_entry.tlast = (cur_x == X_LAST);
        wr_entry.rgb   = expand_rgb444(RxData);
        if (cur_x == X_LAST) begin
          x_d = '0;
          if (cur_y == Y_LAST) begin
            y_d        = '0;
            frame_done = 1'b1;
            state_d    = WAIT_SYNC;
          end else begin
            y_d = cur_y + 9'd1;
          end
        end else begin
          x_d = cur_x + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q       <= WAIT_SYNC;
      x_q           <= '0;
      y_q           <= '0;
      frame_cnt_q   <= '0;
      overflow_q    <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      // A set event in the same cycle as clr_status takes priority.
      if (set_ovf) begin
        overflow_q <= 1'b1;
      end else if (clr_status) begin
        overflow_q <= 1'b0;
      end
      if (set_short) begin
        short_frame_q <= 1'b1;
      end else if (clr_status) begin
        short_frame_q <= 1'b0;
      end
    end
  end

  rx_pix_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_entry),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .rd_valid_o (fifo_valid),
    .rd_ready_i (m_axis_video_tready),
    .rd_data_o  (rd_entry)
  );

  assign unused_fifo_status = ^{fifo_empty, fifo_count};

  assign m_axis_video_tvalid = fifo_valid;
  assign m_axis_video_tdata  = rd_entry.rgb;
  assign m_axis_video_tuser  = rd_entry.tuser;
  assign m_axis_video_tlast  = rd_entry.tlast;
  assign frame_cnt           = frame_cnt_q;
  assign overflow            = overflow_q;
  assign short_frame         = short_frame_q;

endmodule

// File: tb/tb_rx_video_unpack.sv
// Directed bench for rx_video_unpack using a reduced 16x8 frame so a full
// frame, backpressure, early sync and mid-frame reset all fit in a short run.
module tb_rx_video_unpack;

  localparam int H = 16;
  localparam int V = 8;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [11:0] RxData = '0;
  logic        RxValid = 1'b0;
  logic        FrameSync = 1'b0;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tuser;
  logic        tlast;
  logic [15:0] frame_cnt;
  logic        overflow;
  logic        short_frame;
  logic        clr_status = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [25:0] beats[$];

  rx_video_unpack #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FIFO_DEPTH (D)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .RxData              (RxData),
    .RxValid             (RxValid),
    .FrameSync           (FrameSync),
    .m_axis_video_tdata  (tdata),
    .m_axis_video_tvalid (tvalid),
    .m_axis_video_tready (tready),
    .m_axis_video_tuser  (tuser),
    .m_axis_video_tlast  (tlast),
    .frame_cnt           (frame_cnt),
    .overflow            (overflow),
    .short_frame         (short_frame),
    .clr_status          (clr_status)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees what the DUT will sample.
  always @(negedge clk) begin
    if (tvalid && tready) beats.push_back({tuser, tlast, tdata});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-22s got 0x%0h ok", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [11:0] p);
    RxData  = p;
    RxValid = 1'b1;
    tick(1);
    RxValid = 1'b0;
  endtask

  task automatic sync();
    FrameSync = 1'b1;
    tick(1);
    FrameSync = 1'b0;
  endtask

  function automatic logic [23:0] exp_rgb(input logic [11:0] p);
    return {8'(p[11:8] * 17), 8'(p[7:4] * 17), 8'(p[3:0] * 17)};
  endfunction

  function automatic logic [11:0] nom_pix(input int i);
    if (i == 0) return 12'hF80;
    if (i == 1) return 12'h1A3;
    return 12'(i * 37 + 5);
  endfunction

  function automatic logic [11:0] bp_pix(input int i);
    return 12'(i * 111 + 7);
  endfunction

  initial begin
    int errs;
    int nlast;

    // Reset state
    tick(3);
    check_val("rst_tvalid", 32'(tvalid), 32'd0);
    check_val("rst_tuser", 32'(tuser), 32'd0);
    check_val("rst_tlast", 32'(tlast), 32'd0);
    check_val("rst_tdata", 32'(tdata), 32'd0);
    check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_short_frame", 32'(short_frame), 32'd0);
    rstn = 1'b0;
    tick(2);

    // Pixels before any FrameSync are ignored
    beats.delete();
    for (int i = 0; i < 3; i++) send_pixel(12'hABC);
    tick(4);
    check_val("wait_sync_ignored", 32'(beats.size()), 32'd0);

    // Nominal frame with latency and expansion checks
    beats.delete();
    sync();
    RxData = nom_pix(0); RxValid = 1'b1;
    tick(1);
    check_val("latency_edge_n", 32'(tvalid), 32'd0);
    RxData = nom_pix(1);
    tick(1);
    check_val("latency_edge_n1", 32'(tvalid), 32'd1);
    check_val("first_tdata", 32'(tdata), 32'h00FF8800);
    check_val("first_tuser", 32'(tuser), 32'd1);
    RxValid = 1'b0;
    for (int i = 2; i < H * V; i++) send_pixel(nom_pix(i));
    tick(5);
    check_val("nom_beats", 32'(beats.size()), 32'(H * V));
    if (beats.size() == H * V) begin
      check_val("nom_beat0", 32'(beats[0]), {6'd0, 2'b10, 24'hFF8800});
      check_val("nom_beat1", 32'(beats[1]), {6'd0, 2'b00, 24'h11AA33});
      errs = 0;
      nlast = 0;
      for (int i = 0; i < H * V; i++) begin
        if (beats[i] !== {(i == 0), (i % H == H - 1), exp_rgb(nom_pix(i))}) errs++;
        if (beats[i][24]) nlast++;
      end
      check_val("nom_beat_errs", 32'(errs), 32'd0);
      check_val("nom_tlast_count", 32'(nlast), 32'(V));
    end
    check_val("nom_frame_cnt", 32'(frame_cnt), 32'd1);
    beats.delete();
    for (int i = 0; i < 4; i++) send_pixel(12'h555);
    tick(4);
    check_val("back_to_wait_sync", 32'(beats.size()), 32'd0);

    // Backpressure: fill, overflow, drop until next FrameSync
    beats.delete();
    tready = 1'b0;
    sync();
    for (int i = 0; i < 20; i++) send_pixel(bp_pix(i));
    check_val("bp_overflow", 32'(overflow), 32'd1);
    check_val("bp_tvalid_held", 32'(tvalid), 32'd1);
    check_val("bp_tdata_held", 32'(tdata), 32'(exp_rgb(bp_pix(0))));
    tready = 1'b1;
    for (int i = 0; i < 25; i++) send_pixel(12'hFFF);
    tick(3);
    check_val("bp_drained", 32'(beats.size()), 32'(D));
    if (beats.size() == D) begin
      errs = 0;
      for (int i = 0; i < D; i++)
        if (beats[i] !== {(i == 0), (i == H - 1), exp_rgb(bp_pix(i))}) errs++;
      check_val("bp_order_errs", 32'(errs), 32'd0);
    end
    check_val("bp_frame_cnt", 32'(frame_cnt), 32'd1);

    // FrameSync together with RxValid while in DROP
    beats.delete();
    FrameSync = 1'b1; RxData = 12'hABC; RxValid = 1'b1;
    tick(1);
    FrameSync = 1'b0; RxValid = 1'b0;
    tick(3);
    check_val("drop_sync_beats", 32'(beats.size()), 32'd1);
    if (beats.size() == 1) check_val("drop_sync_beat", 32'(beats[0]), {6'd0, 2'b10, 24'hAABBCC});
    check_val("ovf_sticky", 32'(overflow), 32'd1);

    // Early FrameSync at line 5 pixel 5
    for (int i = 1; i < 5 * H + 5; i++) send_pixel(12'(i));
    check_val("pre_early_short", 32'(short_frame), 32'd0);
    sync();
    send_pixel(12'h123);
    tick(3);
    check_val("early_short_frame", 32'(short_frame), 32'd1);
    check_val("early_beats", 32'(beats.size()), 32'(5 * H + 6));
    if (beats.size() == 5 * H + 6) begin
      check_val("early_prev_beat", 32'(beats[5 * H + 4]), {6'd0, 2'b00, exp_rgb(12'(5 * H + 4))});
      check_val("early_tuser_beat", 32'(beats[5 * H + 5]), {6'd0, 2'b10, 24'h112233});
    end
    check_val("early_frame_cnt", 32'(frame_cnt), 32'd1);

    // clr_status colliding with a new short_frame set, then a plain clear
    FrameSync = 1'b1; clr_status = 1'b1;
    tick(1);
    FrameSync = 1'b0; clr_status = 1'b0;
    check_val("clr_vs_set_short", 32'(short_frame), 32'd1);
    check_val("clr_overflow", 32'(overflow), 32'd0);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    check_val("clr_short", 32'(short_frame), 32'd0);

    // Asynchronous reset mid-frame with entries queued
    tready = 1'b1;
    sync();
    for (int i = 0; i < 3 * H; i++) send_pixel(12'(i));
    tick(2);
    tready = 1'b0;
    for (int i = 0; i < 8; i++) send_pixel(12'(i + 200));
    check_val("pre_reset_tvalid", 32'(tvalid), 32'd1);
    #2 rstn = 1'b1;
    #1;
    check_val("async_rst_tvalid", 32'(tvalid), 32'd0);
    check_val("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    tick(1);
    rstn = 1'b0;
    tready = 1'b1;
    tick(1);
    beats.delete();
    for (int i = 0; i < 10; i++) send_pixel(12'(i + 300));
    tick(4);
    check_val("post_rst_no_beats", 32'(beats.size()), 32'd0);
    sync();
    send_pixel(12'h5A7);
    tick(3);
    check_val("post_rst_beats", 32'(beats.size()), 32'd1);
    if (beats.size() == 1) check_val("post_rst_beat", 32'(beats[0]), {6'd0, 2'b10, 24'h55AA77});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_video_unpack.md
# rx_video_unpack

Receive-side video reassembler for the drone camera radio link. It takes 12-bit pixels delivered by the CC1200 SPI receive path (RxData/RxValid/FrameSync) and expands each to 24-bit RGB. It rebuilds frame and line framing and presents the result as an AXI4-Stream video master (tuser = start of frame, tlast = end of line) toward the receive frame memory / HDMI output. A small internal FIFO absorbs downstream backpressure.

## Interface
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2)
- clk  in  1  system clock
- rstn  in  1  reset: asynchronous, active-high (rstn=1 holds block in reset)
- RxData  in  12  received pixel: [11:8]=R4, [7:4]=G4, [3:0]=B4
- RxValid  in  1  one-cycle strobe, RxData valid
- FrameSync  in  1  one-cycle pulse, new frame begins; the next accepted pixel is pixel (0,0)
- m_axis_video_tdata  out  24  {R8,G8,B8}
- m_axis_video_tvalid  out  1  stream valid
- m_axis_video_tready  in  1  stream ready
- m_axis_video_tuser  out  1  first pixel of frame
- m_axis_video_tlast  out  1  last pixel of line
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0
- overflow  out  1  sticky: pixel dropped because FIFO full
- short_frame  out  1  sticky: FrameSync arrived before V_ACTIVE lines completed
- clr_status  in  1  one-cycle pulse, clears both sticky flags

## Operation
- Expansion: each 4-bit channel c is mapped to {c,c}. Example: 12'hF80 -> 24'hFF8800.
- FSM states: WAIT_SYNC (reset state), RECV, DROP.
- WAIT_SYNC: RxValid is ignored. FrameSync -> RECV, x=0, y=0.
- RECV: each RxValid writes {tuser,tlast,pixel} to the FIFO.
  - tuser = (x==0 && y==0).
  - tlast = (x==H_ACTIVE-1).
  - x increments; at H_ACTIVE-1, x=0 and y increments.
  - On the last pixel of line V_ACTIVE-1: frame_cnt+1 -> WAIT_SYNC.
- FrameSync in RECV with x|y != 0: set short_frame, restart x=y=0, stay in RECV. frame_cnt is not incremented.
- RxValid with FIFO full (in RECV): pixel discarded, overflow set -> DROP.
- DROP: discard all RxValid. FrameSync -> RECV with x=y=0. The FIFO is not flushed; queued pixels still drain.
- FrameSync and RxValid in the same cycle: FrameSync is processed first, so that pixel is (0,0) with tuser=1. This applies in all states.
- clr_status and a new set event in the same cycle: the set wins.

## Timing
- Reset values:
  - tvalid=0, tuser=0, tlast=0, tdata=0.
  - frame_cnt=0, overflow=0, short_frame=0.
  - FSM=WAIT_SYNC, FIFO empty, x=y=0.
- Latency: RxValid at edge N, FIFO empty -> tvalid=1 with that pixel after edge N+1 (1-cycle, registered output).
- AXI handshake:
  - Beat transfers on tvalid&tready.
  - tdata/tuser/tlast are held stable while tvalid&!tready.
  - tvalid never drops without a transfer.
- Throughput: 1 pixel/clk sustained when tready=1. FIFO write and read in the same cycle while full is allowed; the occupancy check uses the pre-read count, so a write while full drops.
- Counters: x is 10 bits, y is 9 bits. The FIFO pointers are log2(FIFO_DEPTH)+1 bits, using MSB wrap for the full/empty distinction.
- Reset asserted mid-frame: all state clears immediately (asynchronous). The FIFO contents are lost and tvalid deasserts.

## Structure
- Shared package rx_video_pkg holds:
  - defaults for H_ACTIVE/V_ACTIVE;
  - the FSM state encoding (WAIT_SYNC=0, RECV=1, DROP=2);
  - the FIFO entry width constant (26 = tuser+tlast+24 data).
- One sub-module: rx_pix_fifo, a synchronous FIFO with registered output stage, parameterised width/depth, with full/empty/count outputs.
- Top level contains the FSM, x/y counters, expansion logic, and status registers.

## Test plan
- Nominal frame: FrameSync, then 640x480 RxValid pixels, tready=1 -> 307200 beats; tuser only on beat 0; tlast on every 640th beat; frame_cnt=1; FSM back to WAIT_SYNC.
- Expansion: RxData 12'hF80, 12'h1A3 -> tdata 24'hFF8800, 24'h11AA33.
- Backpressure: tready=0 for 20 cycles with continuous RxValid -> 16 pixels queued, overflow=1, later pixels dropped until the next FrameSync. After tready=1, exactly 16 beats drain in order.
- Early FrameSync: at line 100 pixel 5 -> short_frame=1, the next pixel carries tuser=1, frame_cnt unchanged.
- Simultaneous FrameSync+RxValid while in DROP -> that pixel is emitted with tuser=1; clr_status then clears overflow/short_frame to 0.
- Reset mid-frame: rstn=1 pulse during line 3 with FIFO holding 8 entries -> tvalid=0 immediately; pixels before the next FrameSync produce no beats.
